trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
- Machine-mode trap sequencer for the single-hart core. Consumes the ecall/ebreak exception, mret return and WFI indications from the execute stage, plus external and timer interrupt lines.
- Owns mepc, mcause, mtvec and mstatus.MIE/MPIE.
- Sequences trap entry and return: flush the pipeline, update CSRs, redirect the PC.
- Stalls fetch while a WFI is outstanding.

Parameters:
- XLEN, 32, width of PC and CSR data.
- RESET_MTVEC, 32'h0000_0100, mtvec value after reset.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  execute stage retiring an instruction this cycle
- instr_pc  in  XLEN  PC of that instruction
- exception_valid_in  in  1  synchronous exception (qualified by instr_valid)
- exception_num_in  in  6  exception code (3 = ebreak, 11 = ecall-M)
- exception_return_valid_in  in  1  mret retiring
- wfi_valid_in  in  1  wfi retiring
- ext_irq  in  1  level external interrupt
- timer_irq  in  1  level timer interrupt
- csr_write_valid  in  1  CSR unit write strobe
- csr_addr  in  12  CSR address (0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause)
- csr_wdata  in  XLEN  CSR write data
- stall_out  out  1  hold fetch/decode
- flush_out  out  1  kill younger in-flight instructions
- pc_redirect_valid  out  1  one-cycle redirect pulse
- pc_redirect  out  XLEN  redirect target
- mepc_out, mcause_out, mtvec_out, mstatus_out  out  XLEN each  CSR read values

Behaviour:
- Reset (async, while reset = 1):
  - state = IDLE.
  - All outputs 0 except mtvec_out = RESET_MTVEC.
  - mepc = mcause = 0; MIE = MPIE = 0.
- States: IDLE, TRAP_ENTER, RETURN, WFI_WAIT, REDIRECT.
- IDLE, evaluated each cycle:
  - Event priority when instr_valid = 1: exception > mret > wfi. Lower-priority strobes asserted in the same cycle are ignored.
  - Exception -> TRAP_ENTER. Latch cause = {1'b0, 25'b0, exception_num_in} and epc = instr_pc.
  - mret -> RETURN.
  - wfi -> WFI_WAIT. Latch epc = instr_pc + 4 as the resume PC.
  - Interrupts, only with no instr_valid event and MIE = 1:
    - ext_irq -> TRAP_ENTER with cause 0x8000_000B, epc = instr_pc.
    - Else timer_irq -> TRAP_ENTER with cause 0x8000_0007.
    - External beats timer when both are pending.
- TRAP_ENTER (1 cycle):
  - flush_out = 1, stall_out = 1.
  - mepc <= epc with bits[1:0] forced 0; mcause <= cause; MPIE <= MIE; MIE <= 0.
  - Target = {mtvec[XLEN-1:2], 2'b00}. Direct mode only; mtvec[1:0] is read as 0 and writes to it are ignored.
  - Next state REDIRECT.
- RETURN (1 cycle): flush_out = 1, stall_out = 1; MIE <= MPIE; MPIE <= 1; target = mepc; next state REDIRECT.
- REDIRECT (1 cycle): pc_redirect_valid = 1, pc_redirect = target, stall_out = 1; next state IDLE.
- Latency: event at cycle N -> flush at N+1 -> redirect pulse at N+2 -> first new fetch at N+3.
- WFI_WAIT:
  - stall_out = 1.
  - Wake when (ext_irq | timer_irq) = 1, regardless of MIE.
  - Wake with MIE = 1 -> TRAP_ENTER with the interrupt cause; epc = latched resume PC.
  - Wake with MIE = 0 -> REDIRECT to the resume PC; no CSR update.
- CSR writes:
  - Accepted only in IDLE and WFI_WAIT; dropped silently in TRAP_ENTER, RETURN and REDIRECT.
  - mstatus write updates only MIE (bit 3) and MPIE (bit 7). mstatus_out returns those two bits with all other bits 0.
  - mepc write forces bits[1:0] to 0.
- Same-cycle collision: a hardware trap-entry write to mepc/mcause and a CSR write to the same register -> the hardware write wins.
- Reset mid-sequence: return to IDLE immediately and drop any pending redirect; no pulse is issued after reset deassertion.
- Adder: instr_pc + 4 is XLEN wide and wraps modulo 2^XLEN.

Decomposition:
- Package trap_pkg holds:
  - state enum trap_state_t;
  - CSR address constants;
  - cause constants (EXC_EBREAK = 3, EXC_ECALL_M = 11, IRQ_TIMER = 7, IRQ_EXT = 11);
  - INTERRUPT_BIT = XLEN-1.
- One natural sub-module: trap_csr_file, holding the mepc/mcause/mtvec/mstatus registers, the write arbitration and the read outputs. The FSM stays in trap_sequencer.

Test Plan:
- ecall at pc 0x200 with mtvec = 0x100 -> flush at N+1; redirect 0x100 at N+2; mepc = 0x200; mcause = 11; MIE 1 -> 0; MPIE = 1.
- mret after the trap above -> redirect 0x200 at N+2; MIE restored to 1; MPIE = 1.
- wfi at pc 0x300 with MIE = 0, timer_irq raised 5 cycles later -> stall_out held 5 cycles, then redirect 0x304, mcause unchanged.
- wfi at pc 0x300 with MIE = 1, ext_irq and timer_irq raised together -> mcause = 0x8000_000B, mepc = 0x304, redirect to mtvec.
- exception, mret and wfi strobes in the same cycle at pc 0x400 -> exception path only; mcause = exception_num_in; mepc = 0x400.
- reset asserted during TRAP_ENTER -> outputs 0 asynchronously; after release, no pc_redirect_valid pulse appears and mtvec = RESET_MTVEC.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRAP_ENTER,
    ST_RETURN,
    ST_WFI_WAIT,
    ST_REDIRECT
  } trap_state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [5:0] EXC_EBREAK  = 6'd3;
  localparam logic [5:0] EXC_ECALL_M = 6'd11;
  localparam logic [5:0] IRQ_TIMER   = 6'd7;
  localparam logic [5:0] IRQ_EXT     = 6'd11;

  localparam int XLEN_DEFAULT  = 32;
  localparam int INTERRUPT_BIT = XLEN_DEFAULT - 1;
  localparam int MSTATUS_MIE   = 3;
  localparam int MSTATUS_MPIE  = 7;

endpackage

// File: rtl/trap_csr_file.sv
// mepc/mcause/mtvec/mstatus storage; hardware trap/return updates take priority
// over software CSR writes to the same register.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_csr_we,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  input  logic            i_trap_en,
  input  logic [XLEN-1:0] i_trap_epc,
  input  logic [XLEN-1:0] i_trap_cause,
  input  logic            i_ret_en,
  output logic [XLEN-1:0] o_mepc,
  output logic [XLEN-1:0] o_mcause,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mstatus,
  output logic            o_mie
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] r_mepc, r_mcause, r_mtvec;
  logic            r_mie, r_mpie;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtvec  <= RESET_MTVEC & ALIGN_MASK;
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
    end else begin
      if (i_trap_en)
        r_mepc <= i_trap_epc & ALIGN_MASK;
      else if (i_csr_we && i_csr_addr == CSR_MEPC)
        r_mepc <= i_csr_wdata & ALIGN_MASK;

      if (i_trap_en)
        r_mcause <= i_trap_cause;
      else if (i_csr_we && i_csr_addr == CSR_MCAUSE)
        r_mcause <= i_csr_wdata;

      // Direct mode only: mode bits are hardwired to zero.
      if (i_csr_we && i_csr_addr == CSR_MTVEC)
        r_mtvec <= i_csr_wdata & ALIGN_MASK;

      if (i_trap_en) begin
        r_mpie <= r_mie;
        r_mie  <= 1'b0;
      end else if (i_ret_en) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (i_csr_we && i_csr_addr == CSR_MSTATUS) begin
        r_mie  <= i_csr_wdata[MSTATUS_MIE];
        r_mpie <= i_csr_wdata[MSTATUS_MPIE];
      end
    end
  end

  always_comb begin
    o_mstatus               = '0;
    o_mstatus[MSTATUS_MIE]  = r_mie;
    o_mstatus[MSTATUS_MPIE] = r_mpie;
  end

  assign o_mepc   = r_mepc;
  assign o_mcause = r_mcause;
  assign o_mtvec  = r_mtvec;
  assign o_mie    = r_mie;

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: takes exceptions, mret, wfi and interrupts,
// flushes the pipe, updates CSRs and issues a one-cycle PC redirect.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instr_pc,
  input  logic            exception_valid_in,
  input  logic [5:0]      exception_num_in,
  input  logic            exception_return_valid_in,
  input  logic            wfi_valid_in,
  input  logic            ext_irq,
  input  logic            timer_irq,
  input  logic            csr_write_valid,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic            stall_out,
  output logic            flush_out,
  output logic            pc_redirect_valid,
  output logic [XLEN-1:0] pc_redirect,
  output logic [XLEN-1:0] mepc_out,
  output logic [XLEN-1:0] mcause_out,
  output logic [XLEN-1:0] mtvec_out,
  output logic [XLEN-1:0] mstatus_out
);

  localparam logic [XLEN-1:0] CAUSE_EXT   = {1'b1, {(XLEN-7){1'b0}}, IRQ_EXT};
  localparam logic [XLEN-1:0] CAUSE_TIMER = {1'b1, {(XLEN-7){1'b0}}, IRQ_TIMER};

  trap_state_t     r_state, w_next;
  logic [XLEN-1:0] r_epc, r_cause, r_target;
  logic [XLEN-1:0] w_exc_cause, w_irq_cause, w_resume;
  logic            w_ev_exc, w_ev_mret, w_ev_wfi, w_ev_any, w_irq, w_mie;
  logic            w_csr_we, w_trap_en, w_ret_en;

  // Priority among retiring strobes: exception > mret > wfi.
  assign w_ev_exc    = instr_valid & exception_valid_in;
  assign w_ev_mret   = instr_valid & exception_return_valid_in & ~exception_valid_in;
  assign w_ev_wfi    = instr_valid & wfi_valid_in & ~exception_valid_in
                       & ~exception_return_valid_in;
  assign w_ev_any    = w_ev_exc | w_ev_mret | w_ev_wfi;
  assign w_irq       = ext_irq | timer_irq;
  assign w_irq_cause = ext_irq ? CAUSE_EXT : CAUSE_TIMER;
  assign w_exc_cause = {{(XLEN-6){1'b0}}, exception_num_in};
  assign w_resume    = instr_pc + XLEN'(4);
  assign w_csr_we    = csr_write_valid & (r_state == ST_IDLE || r_state == ST_WFI_WAIT);
  assign w_trap_en   = (r_state == ST_TRAP_ENTER);
  assign w_ret_en    = (r_state == ST_RETURN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if      (w_ev_exc)       w_next = ST_TRAP_ENTER;
        else if (w_ev_mret)      w_next = ST_RETURN;
        else if (w_ev_wfi)       w_next = ST_WFI_WAIT;
        else if (w_mie && w_irq) w_next = ST_TRAP_ENTER;
      end
      ST_TRAP_ENTER: w_next = ST_REDIRECT;
      ST_RETURN:     w_next = ST_REDIRECT;
      ST_WFI_WAIT:   if (w_irq) w_next = w_mie ? ST_TRAP_ENTER : ST_REDIRECT;
      ST_REDIRECT:   w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_out         = 1'b0;
    flush_out         = 1'b0;
    pc_redirect_valid = 1'b0;
    pc_redirect       = '0;
    case (r_state)
      ST_TRAP_ENTER, ST_RETURN: begin
        stall_out = 1'b1;
        flush_out = 1'b1;
      end
      ST_WFI_WAIT: stall_out = 1'b1;
      ST_REDIRECT: begin
        stall_out         = 1'b1;
        pc_redirect_valid = 1'b1;
        pc_redirect       = r_target;
      end
      default: ;
    endcase
  end

  // Latched trap context and redirect target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_epc    <= '0;
      r_cause  <= '0;
      r_target <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ev_exc) begin
            r_epc   <= instr_pc;
            r_cause <= w_exc_cause;
          end else if (w_ev_wfi) begin
            r_epc <= w_resume;
          end else if (!w_ev_any && w_mie && w_irq) begin
            r_epc   <= instr_pc;
            r_cause <= w_irq_cause;
          end
        end
        ST_WFI_WAIT: begin
          if (w_irq && w_mie)  r_cause  <= w_irq_cause;
          else if (w_irq)      r_target <= r_epc;
        end
        ST_TRAP_ENTER: r_target <= {mtvec_out[XLEN-1:2], 2'b00};
        ST_RETURN:     r_target <= mepc_out;
        default: ;
      endcase
    end
  end

  trap_csr_file #(
    .XLEN        (XLEN),
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csr (
    .clk          (clk),
    .reset        (reset),
    .i_csr_we     (w_csr_we),
    .i_csr_addr   (csr_addr),
    .i_csr_wdata  (csr_wdata),
    .i_trap_en    (w_trap_en),
    .i_trap_epc   (r_epc),
    .i_trap_cause (r_cause),
    .i_ret_en     (w_ret_en),
    .o_mepc       (mepc_out),
    .o_mcause     (mcause_out),
    .o_mtvec      (mtvec_out),
    .o_mstatus    (mstatus_out),
    .o_mie        (w_mie)
  );

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed scenarios plus random traffic, checked every cycle against a
// cycle-count based reference model of the trap rules.
module tb_trap_sequencer;

  logic        clk = 1'b0, reset = 1'b1;
  logic        instr_valid, exception_valid_in, exception_return_valid_in, wfi_valid_in;
  logic [31:0] instr_pc, csr_wdata;
  logic [5:0]  exception_num_in;
  logic        ext_irq, timer_irq, csr_write_valid;
  logic [11:0] csr_addr;
  logic        stall_out, flush_out, pc_redirect_valid;
  logic [31:0] pc_redirect, mepc_out, mcause_out, mtvec_out, mstatus_out;

  trap_sequencer #(.XLEN(32), .RESET_MTVEC(32'h0000_0100)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .exception_valid_in(exception_valid_in), .exception_num_in(exception_num_in),
    .exception_return_valid_in(exception_return_valid_in), .wfi_valid_in(wfi_valid_in),
    .ext_irq(ext_irq), .timer_irq(timer_irq), .csr_write_valid(csr_write_valid),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .stall_out(stall_out),
    .flush_out(flush_out), .pc_redirect_valid(pc_redirect_valid),
    .pc_redirect(pc_redirect), .mepc_out(mepc_out), .mcause_out(mcause_out),
    .mtvec_out(mtvec_out), .mstatus_out(mstatus_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, n_redir = 0;
  logic [31:0] last_redir;

  // Reference model: m_left counts remaining cycles of a flush+redirect sequence.
  logic [31:0] m_mepc, m_mcause, m_mtvec, m_tgt, m_epc, m_cause, m_resume;
  bit          m_mie, m_mpie, m_wfi, m_trap;
  int          m_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mepc = 0; m_mcause = 0; m_mtvec = 32'h100; m_tgt = 0; m_epc = 0; m_cause = 0;
    m_resume = 0; m_mie = 0; m_mpie = 0; m_wfi = 0; m_trap = 0; m_left = 0;
  endtask

  task automatic model_adv();
    bit ev_exc, ev_mret, ev_wfi, irq;
    logic [31:0] icause;
    ev_exc  = instr_valid && exception_valid_in;
    ev_mret = instr_valid && exception_return_valid_in && !exception_valid_in;
    ev_wfi  = instr_valid && wfi_valid_in && !exception_valid_in && !exception_return_valid_in;
    irq     = ext_irq || timer_irq;
    icause  = ext_irq ? 32'h8000_000B : 32'h8000_0007;
    if (m_left == 2) begin
      if (m_trap) begin
        m_mepc = m_epc & ~32'h3; m_mcause = m_cause;
        m_mpie = m_mie; m_mie = 0; m_tgt = m_mtvec;
      end else begin
        m_tgt = m_mepc; m_mie = m_mpie; m_mpie = 1;
      end
      m_left = 1;
    end else if (m_left == 1) begin
      m_left = 0;
    end else begin
      if (m_wfi) begin
        if (irq) begin
          m_wfi = 0;
          if (m_mie) begin m_trap = 1; m_cause = icause; m_epc = m_resume; m_left = 2; end
          else begin m_tgt = m_resume; m_left = 1; end
        end
      end else if (ev_exc) begin
        m_trap = 1; m_cause = {26'b0, exception_num_in}; m_epc = instr_pc; m_left = 2;
      end else if (ev_mret) begin
        m_trap = 0; m_left = 2;
      end else if (ev_wfi) begin
        m_wfi = 1; m_resume = instr_pc + 32'd4;
      end else if (m_mie && irq) begin
        m_trap = 1; m_cause = icause; m_epc = instr_pc; m_left = 2;
      end
      if (csr_write_valid) begin
        case (csr_addr)
          12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
          12'h305: m_mtvec  = csr_wdata & ~32'h3;
          12'h341: m_mepc   = csr_wdata & ~32'h3;
          12'h342: m_mcause = csr_wdata;
          default: ;
        endcase
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("flush",   32'(flush_out),         32'(m_left == 2));
    chk("stall",   32'(stall_out),         32'(m_left != 0 || m_wfi));
    chk("rvalid",  32'(pc_redirect_valid), 32'(m_left == 1));
    chk("rpc",     pc_redirect,            (m_left == 1) ? m_tgt : 32'h0);
    chk("mepc",    mepc_out,   m_mepc);
    chk("mcause",  mcause_out, m_mcause);
    chk("mtvec",   mtvec_out,  m_mtvec);
    chk("mstatus", mstatus_out, (32'(m_mpie) << 7) | (32'(m_mie) << 3));
    if (pc_redirect_valid) begin n_redir++; last_redir = pc_redirect; end
    model_adv();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    instr_valid = 0; instr_pc = 0; exception_valid_in = 0; exception_num_in = 0;
    exception_return_valid_in = 0; wfi_valid_in = 0; ext_irq = 0; timer_irq = 0;
    csr_write_valid = 0; csr_addr = 0; csr_wdata = 0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_write_valid = 1; csr_addr = a; csr_wdata = d;
    step();
    idle_in();
  endtask

  task automatic retire(input logic [31:0] pc, input bit e, input logic [5:0] num,
                        input bit r, input bit w);
    instr_valid = 1; instr_pc = pc; exception_valid_in = e; exception_num_in = num;
    exception_return_valid_in = r; wfi_valid_in = w;
    step();
    idle_in();
  endtask

  initial begin
    idle_in();
    model_reset();
    #12;
    chk("rst_stall", 32'(stall_out), 0);
    chk("rst_flush", 32'(flush_out), 0);
    chk("rst_rv",    32'(pc_redirect_valid), 0);
    chk("rst_mtvec", mtvec_out, 32'h100);
    chk("rst_mstat", mstatus_out, 0);
    #11 reset = 0;
    @(posedge clk); #1;

    // ecall at 0x200
    csr_wr(12'h300, 32'h8);
    retire(32'h200, 1, 6'd11, 0, 0);
    repeat (3) step();
    chk("ecall_redir", last_redir, 32'h100);
    chk("ecall_mepc",  mepc_out, 32'h200);
    chk("ecall_cause", mcause_out, 32'd11);
    chk("ecall_mstat", mstatus_out, 32'h80);

    // mret back
    retire(32'h180, 0, 0, 1, 0);
    repeat (3) step();
    chk("mret_redir", last_redir, 32'h200);
    chk("mret_mstat", mstatus_out, 32'h88);

    // wfi, MIE = 0, timer 5 cycles later
    csr_wr(12'h300, 32'h0);
    retire(32'h300, 0, 0, 0, 1);
    repeat (5) step();
    chk("wfi_hold", 32'(stall_out), 1);
    timer_irq = 1;
    step();
    timer_irq = 0;
    repeat (2) step();
    chk("wfi_redir", last_redir, 32'h304);
    chk("wfi_cause", mcause_out, 32'd11);

    // wfi, MIE = 1, both interrupts
    csr_wr(12'h300, 32'h8);
    retire(32'h300, 0, 0, 0, 1);
    step();
    ext_irq = 1; timer_irq = 1;
    step();
    ext_irq = 0; timer_irq = 0;
    repeat (3) step();
    chk("wfiirq_cause", mcause_out, 32'h8000_000B);
    chk("wfiirq_mepc",  mepc_out, 32'h304);
    chk("wfiirq_redir", last_redir, 32'h100);

    // all strobes together
    retire(32'h400, 1, 6'd3, 1, 1);
    repeat (3) step();
    chk("prio_cause", mcause_out, 32'd3);
    chk("prio_mepc",  mepc_out, 32'h400);

    // mtvec mode bits read as zero
    csr_wr(12'h305, 32'h0000_0207);
    chk("mtvec_mask", mtvec_out, 32'h204);

    // reset during TRAP_ENTER
    retire(32'h500, 1, 6'd11, 0, 0);
    chk("pre_rst_flush", 32'(flush_out), 1);
    reset = 1; #1;
    chk("arst_flush", 32'(flush_out), 0);
    chk("arst_stall", 32'(stall_out), 0);
    chk("arst_mepc",  mepc_out, 0);
    chk("arst_mtvec", mtvec_out, 32'h100);
    #1 reset = 0;
    model_reset();
    n_redir = 0;
    repeat (4) step();
    chk("no_redir_after_rst", n_redir, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      instr_valid = 1'($urandom % 2);
      instr_pc = $urandom;
      exception_valid_in = ($urandom % 8) == 0;
      exception_num_in = 6'($urandom);
      exception_return_valid_in = ($urandom % 8) == 0;
      wfi_valid_in = ($urandom % 8) == 0;
      ext_irq = ($urandom % 16) == 0;
      timer_irq = ($urandom % 16) == 0;
      csr_write_valid = ($urandom % 6) == 0;
      case ($urandom % 5)
        0: csr_addr = 12'h300;
        1: csr_addr = 12'h305;
        2: csr_addr = 12'h341;
        3: csr_addr = 12'h342;
        default: csr_addr = 12'($urandom);
      endcase
      csr_wdata = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
